// File: rtl/fat32_mount_if.sv
// Bundle between the FAT32 mount controller, the SD block reader and the file-write logic.
// The master side is the controller; the slave side is its environment.
interface fat32_mount_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        error;
    logic [1:0]  error_code;
    logic        rd_req;
    logic [31:0] rd_lba;
    logic        rd_ack;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic [31:0] partition_lba;
    logic [15:0] reserved_sectors;
    logic [7:0]  num_fats;
    logic [31:0] fat_size;
    logic [7:0]  sectors_per_cluster;
    logic [31:0] root_cluster;
    logic [31:0] fat_start_lba;
    logic [31:0] data_start_lba;
    logic [31:0] root_dir_lba;

    modport master (
        input  start, rd_ack, byte_valid, byte_data,
        output busy, done, error, error_code, rd_req, rd_lba,
               partition_lba, reserved_sectors, num_fats, fat_size,
               sectors_per_cluster, root_cluster,
               fat_start_lba, data_start_lba, root_dir_lba
    );

    modport slave (
        output start, rd_ack, byte_valid, byte_data,
        input  busy, done, error, error_code, rd_req, rd_lba,
               partition_lba, reserved_sectors, num_fats, fat_size,
               sectors_per_cluster, root_cluster,
               fat_start_lba, data_start_lba, root_dir_lba
    );
endinterface

// File: rtl/fat32_mount_controller.sv
// Reads sector 0 (and the partition VBR via MBR entry 0 when present), parses the FAT32 BPB
// and derives FAT, data-region and root-directory sector addresses.
module fat32_mount_controller #(
    parameter int unsigned SECTOR_BYTES = 512,
    parameter bit          USE_MBR      = 1'b1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    fat32_mount_if.master     bus
);

    localparam int unsigned CNT_W = 10;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(SECTOR_BYTES - 1);

    typedef enum logic [3:0] {
        IDLE, REQ, STREAM, CHECK, CALC0, CALC1, CALC2, DONE, ERR
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              pipe_vld_q;
    logic [7:0]        pipe_data_q;
    logic [7:0]        byte0_q;
    logic [15:0]       bps_q;
    logic [31:0]       mbr_lba_q;
    logic [15:0]       sig_q;
    logic              pass2_q, pass2_d;

    logic              busy_d, done_d, error_d, rd_req_d;
    logic [1:0]        code_d;
    logic [31:0]       rd_lba_d, part_d;
    logic              is_vbr, geom_ok;
    logic [2:0]        spc_log2;

    function automatic logic [2:0] log2_8(input logic [7:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) r = 3'(i);
        end
        return r;
    endfunction

    assign is_vbr  = ((byte0_q == 8'hEB) || (byte0_q == 8'hE9)) && (bps_q == 16'(SECTOR_BYTES));
    assign geom_ok = ((bus.num_fats == 8'd1) || (bus.num_fats == 8'd2)) &&
                     (bus.sectors_per_cluster != 8'd0) &&
                     ((bus.sectors_per_cluster & (bus.sectors_per_cluster - 8'd1)) == 8'd0) &&
                     (bus.root_cluster >= 32'd2);
    assign spc_log2 = log2_8(bus.sectors_per_cluster);

    // Next-state and next values of the registered control outputs
    always_comb begin
        state_d  = state_q;
        busy_d   = bus.busy;
        done_d   = bus.done;
        error_d  = bus.error;
        code_d   = bus.error_code;
        rd_req_d = bus.rd_req;
        rd_lba_d = bus.rd_lba;
        part_d   = bus.partition_lba;
        pass2_d  = pass2_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (bus.start) begin
                    done_d   = 1'b0;
                    error_d  = 1'b0;
                    code_d   = 2'd0;
                    busy_d   = 1'b1;
                    rd_req_d = 1'b1;
                    rd_lba_d = 32'd0;
                    part_d   = 32'd0;
                    pass2_d  = 1'b0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus.rd_ack) begin
                    rd_req_d = 1'b0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (pipe_vld_q && (cnt_q == LAST_IDX)) state_d = CHECK;
            end
            CHECK: begin
                if (sig_q != 16'hAA55) begin
                    state_d = ERR; error_d = 1'b1; busy_d = 1'b0; code_d = 2'd1;
                end else if (!is_vbr) begin
                    if (USE_MBR && !pass2_q) begin
                        if (mbr_lba_q == 32'd0) begin
                            state_d = ERR; error_d = 1'b1; busy_d = 1'b0; code_d = 2'd3;
                        end else begin
                            part_d   = mbr_lba_q;
                            pass2_d  = 1'b1;
                            rd_req_d = 1'b1;
                            rd_lba_d = mbr_lba_q;
                            state_d  = REQ;
                        end
                    end else begin
                        state_d = ERR; error_d = 1'b1; busy_d = 1'b0; code_d = 2'd2;
                    end
                end else if (!geom_ok) begin
                    state_d = ERR; error_d = 1'b1; busy_d = 1'b0; code_d = 2'd3;
                end else begin
                    state_d = CALC0;
                end
            end
            CALC0: state_d = CALC1;
            CALC1: state_d = CALC2;
            CALC2: begin
                state_d = DONE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // State, control outputs, byte capture and address arithmetic
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q                 <= IDLE;
            cnt_q                   <= '0;
            pipe_vld_q              <= 1'b0;
            pipe_data_q             <= 8'd0;
            byte0_q                 <= 8'd0;
            bps_q                   <= 16'd0;
            mbr_lba_q               <= 32'd0;
            sig_q                   <= 16'd0;
            pass2_q                 <= 1'b0;
            bus.busy                <= 1'b0;
            bus.done                <= 1'b0;
            bus.error               <= 1'b0;
            bus.error_code          <= 2'd0;
            bus.rd_req              <= 1'b0;
            bus.rd_lba              <= 32'd0;
            bus.partition_lba       <= 32'd0;
            bus.reserved_sectors    <= 16'd0;
            bus.num_fats            <= 8'd0;
            bus.fat_size            <= 32'd0;
            bus.sectors_per_cluster <= 8'd0;
            bus.root_cluster        <= 32'd0;
            bus.fat_start_lba       <= 32'd0;
            bus.data_start_lba      <= 32'd0;
            bus.root_dir_lba        <= 32'd0;
        end else begin
            state_q           <= state_d;
            pass2_q           <= pass2_d;
            bus.busy          <= busy_d;
            bus.done          <= done_d;
            bus.error         <= error_d;
            bus.error_code    <= code_d;
            bus.rd_req        <= rd_req_d;
            bus.rd_lba        <= rd_lba_d;
            bus.partition_lba <= part_d;
            // Input stage register: a byte is only taken while streaming
            pipe_vld_q  <= bus.byte_valid && (state_q == STREAM);
            pipe_data_q <= bus.byte_data;

            if (state_q == REQ) cnt_q <= '0;

            if (pipe_vld_q && (state_q == STREAM)) begin
                cnt_q <= cnt_q + CNT_W'(1);
                case (cnt_q)
                    10'h000: byte0_q                       <= pipe_data_q;
                    10'h00B: bps_q[7:0]                    <= pipe_data_q;
                    10'h00C: bps_q[15:8]                   <= pipe_data_q;
                    10'h00D: bus.sectors_per_cluster       <= pipe_data_q;
                    10'h00E: bus.reserved_sectors[7:0]     <= pipe_data_q;
                    10'h00F: bus.reserved_sectors[15:8]    <= pipe_data_q;
                    10'h010: bus.num_fats                  <= pipe_data_q;
                    10'h024: bus.fat_size[7:0]             <= pipe_data_q;
                    10'h025: bus.fat_size[15:8]            <= pipe_data_q;
                    10'h026: bus.fat_size[23:16]           <= pipe_data_q;
                    10'h027: bus.fat_size[31:24]           <= pipe_data_q;
                    10'h02C: bus.root_cluster[7:0]         <= pipe_data_q;
                    10'h02D: bus.root_cluster[15:8]        <= pipe_data_q;
                    10'h02E: bus.root_cluster[23:16]       <= pipe_data_q;
                    10'h02F: bus.root_cluster[31:24]       <= pipe_data_q;
                    10'h1C6: mbr_lba_q[7:0]                <= pipe_data_q;
                    10'h1C7: mbr_lba_q[15:8]               <= pipe_data_q;
                    10'h1C8: mbr_lba_q[23:16]              <= pipe_data_q;
                    10'h1C9: mbr_lba_q[31:24]              <= pipe_data_q;
                    10'h1FE: sig_q[7:0]                    <= pipe_data_q;
                    10'h1FF: sig_q[15:8]                   <= pipe_data_q;
                    default: ;
                endcase
            end

            case (state_q)
                CALC0: bus.fat_start_lba  <= bus.partition_lba + 32'(bus.reserved_sectors);
                CALC1: bus.data_start_lba <= bus.fat_start_lba + 32'(32'(bus.num_fats) * bus.fat_size);
                CALC2: bus.root_dir_lba   <= bus.data_start_lba + ((bus.root_cluster - 32'd2) << spc_log2);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fat32_mount_controller.sv
// Directed bench for fat32_mount_controller: VBR-only, MBR->VBR, signature/geometry errors,
// slow reader handshake and mid-stream reset.
module tb_fat32_mount_controller;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    int   tests   = 0;
    int   fails   = 0;
    int   reads   = 0;
    int   rbase   = 0;

    logic [7:0] sec [2][512];

    fat32_mount_if bus ();

    fat32_mount_controller #(.SECTOR_BYTES(512), .USE_MBR(1'b1)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) if (!sys_rst && bus.rd_req && bus.rd_ack) reads <= reads + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic build_vbr(input int sel, input logic [15:0] rsvd, input logic [7:0] fats,
                             input logic [31:0] fsz, input logic [7:0] spc, input logic [31:0] rc);
        for (int i = 0; i < 512; i++) sec[sel][i] = 8'h00;
        sec[sel][0]    = 8'hEB;  sec[sel][1] = 8'h58;  sec[sel][2] = 8'h90;
        sec[sel][11]   = 8'h00;  sec[sel][12] = 8'h02;
        sec[sel][13]   = spc;
        sec[sel][14]   = rsvd[7:0];  sec[sel][15] = rsvd[15:8];
        sec[sel][16]   = fats;
        for (int b = 0; b < 4; b++) begin
            sec[sel][36 + b] = fsz[8*b +: 8];
            sec[sel][44 + b] = rc[8*b +: 8];
        end
        sec[sel][510]  = 8'h55;  sec[sel][511] = 8'hAA;
    endtask

    task automatic build_mbr(input int sel, input logic [31:0] lba);
        for (int i = 0; i < 512; i++) sec[sel][i] = 8'h00;
        sec[sel][0] = 8'hFA;
        for (int b = 0; b < 4; b++) sec[sel][454 + b] = lba[8*b +: 8];
        sec[sel][510] = 8'h55;  sec[sel][511] = 8'hAA;
    endtask

    task automatic pulse_start();
        rbase = reads;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("busy_after_start", 64'(bus.busy), 64'd1);
    endtask

    task automatic stream(input int sel, input int nbytes, input int gap);
        for (int i = 0; i < nbytes; i++) begin
            bus.byte_valid = 1'b1;
            bus.byte_data  = sec[sel][i];
            tick();
            bus.byte_valid = 1'b0;
            if (gap != 0 && (i % gap) == gap - 1) tick();
        end
        bus.byte_valid = 1'b0;
    endtask

    task automatic serve(input int sel, input logic [31:0] exp_lba, input int ack_dly,
                         input int gap, input int nbytes);
        int n;
        n = 0;
        while (!bus.rd_req && n < 50) begin tick(); n++; end
        chk("req_seen", 64'(bus.rd_req), 64'd1);
        chk("rd_lba", 64'(bus.rd_lba), 64'(exp_lba));
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            chk("req_hold", {31'd0, bus.rd_req, bus.rd_lba}, {31'd0, 1'b1, exp_lba});
        end
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        chk("req_drop", 64'(bus.rd_req), 64'd0);
        stream(sel, nbytes, gap);
    endtask

    task automatic wait_end();
        int n;
        n = 0;
        while (!(bus.done || bus.error) && n < 100) begin tick(); n++; end
        chk("finished", 64'(bus.done | bus.error), 64'd1);
    endtask

    task automatic chk_results(input string tag, input logic [31:0] fs, input logic [31:0] ds,
                               input logic [31:0] rd, input int nreads);
        chk({tag, "_done"}, {bus.busy, bus.done, bus.error}, 64'b010);
        chk({tag, "_fat_start"}, 64'(bus.fat_start_lba), 64'(fs));
        chk({tag, "_data_start"}, 64'(bus.data_start_lba), 64'(ds));
        chk({tag, "_root_dir"}, 64'(bus.root_dir_lba), 64'(rd));
        chk({tag, "_reads"}, 64'(reads - rbase), 64'(nreads));
    endtask

    task automatic chk_error(input string tag, input logic [1:0] code, input int nreads);
        chk({tag, "_flags"}, {bus.busy, bus.done, bus.error}, 64'b001);
        chk({tag, "_code"}, 64'(bus.error_code), 64'(code));
        chk({tag, "_reads"}, 64'(reads - rbase), 64'(nreads));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_ctl"}, {bus.busy, bus.done, bus.error, bus.error_code, bus.rd_req}, 64'd0);
        chk({tag, "_lba"}, {bus.rd_lba, bus.partition_lba}, 64'd0);
        chk({tag, "_fields"}, {bus.reserved_sectors, bus.num_fats, bus.sectors_per_cluster,
                               bus.fat_size | bus.root_cluster}, 64'd0);
        chk({tag, "_addrs"}, {bus.fat_start_lba | bus.data_start_lba, bus.root_dir_lba}, 64'd0);
    endtask

    task automatic run_test1(input string tag, input int ack_dly, input int gap);
        build_vbr(0, 16'd32, 8'd2, 32'd961, 8'd8, 32'd2);
        pulse_start();
        serve(0, 32'd0, ack_dly, gap, 512);
        if (gap == 0) begin
            repeat (4) tick();
            chk({tag, "_not_early"}, 64'(bus.done), 64'd0);
            tick();
            chk({tag, "_done_5th_edge"}, 64'(bus.done), 64'd1);
        end else begin
            wait_end();
        end
        chk_results(tag, 32'd32, 32'd1954, 32'd1954, 1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.rd_ack     = 1'b0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        repeat (3) tick();
        chk_zero("reset");
        sys_rst = 1'b0;
        tick();

        // 1: VBR directly in sector 0
        run_test1("t1", 0, 0);
        tick();

        // 2: MBR in sector 0 pointing to a VBR at 8192
        build_mbr(0, 32'd8192);
        build_vbr(1, 16'd32, 8'd2, 32'd961, 8'd8, 32'd5);
        pulse_start();
        chk("t2_restart_clears_done", 64'(bus.done), 64'd0);
        serve(0, 32'd0, 0, 0, 512);
        serve(1, 32'd8192, 0, 0, 512);
        wait_end();
        chk("t2_partition", 64'(bus.partition_lba), 64'd8192);
        chk_results("t2", 32'd8224, 32'd10146, 32'd10170, 2);
        tick();

        // 3: bad signature
        build_vbr(0, 16'd32, 8'd2, 32'd961, 8'd8, 32'd2);
        sec[0][511] = 8'hAB;
        pulse_start();
        serve(0, 32'd0, 0, 0, 512);
        wait_end();
        chk_error("t3", 2'd1, 1);
        tick();

        // 4: bad geometry, spc not a power of two, then three FATs
        build_vbr(0, 16'd32, 8'd2, 32'd961, 8'd6, 32'd2);
        pulse_start();
        serve(0, 32'd0, 0, 0, 512);
        wait_end();
        chk_error("t4a", 2'd3, 1);
        tick();
        build_vbr(0, 16'd32, 8'd3, 32'd961, 8'd8, 32'd2);
        pulse_start();
        serve(0, 32'd0, 0, 0, 512);
        wait_end();
        chk_error("t4b", 2'd3, 1);
        tick();

        // 5: slow ack and gapped byte stream
        run_test1("t5", 7, 3);
        tick();

        // 6: reset in the middle of the stream, then a clean mount
        build_vbr(0, 16'd32, 8'd2, 32'd961, 8'd8, 32'd2);
        pulse_start();
        serve(0, 32'd0, 0, 0, 200);
        sys_rst        = 1'b1;
        bus.byte_valid = 1'b1;
        bus.byte_data  = sec[0][200];
        tick();
        chk_zero("t6_rst");
        sys_rst = 1'b0;
        for (int i = 201; i < 260; i++) begin
            bus.byte_data = sec[0][i];
            tick();
        end
        bus.byte_valid = 1'b0;
        chk_zero("t6_after");
        tick();
        run_test1("t6", 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fat32_mount_controller.md
Name: fat32_mount_controller

Overview:
- Sequences SD sector reads to mount a FAT32 volume.
- Requests sector 0 from the SD block reader and follows the MBR partition entry 0 to the volume boot record when one is present.
- Parses the BPB from the byte stream and computes the FAT, data and root-directory sector addresses.
- Sits between the SD reader and the file-write logic; the file-write logic consumes its address outputs after done.

Parameters:
SECTOR_BYTES, 512, bytes per sector streamed by the reader; a BPB bytes_per_sector value other than this is an error.
USE_MBR, 1, 1 = follow MBR partition entry 0 when sector 0 is not a VBR; 0 = sector 0 must be a VBR.

Ports:
sys_clk  in  1  clock, all logic on rising edge
sys_rst  in  1  synchronous active-high reset
start  in  1  single-cycle mount request
busy  out  1  high from accepted start until done/error
done  out  1  level; mount results valid
error  out  1  level; mount failed
error_code  out  2  0 none, 1 no 0x55AA signature, 2 not a VBR or bad bytes/sector, 3 bad geometry
rd_req  out  1  sector read request
rd_lba  out  32  sector address, stable while rd_req high
rd_ack  in  1  reader accepts request
byte_valid  in  1  stream byte strobe
byte_data  in  8  stream byte; bytes arrive in order, index 0..SECTOR_BYTES-1
partition_lba  out  32  volume start sector
reserved_sectors  out  16  BPB 0x0E..0x0F
num_fats  out  8  BPB 0x10
fat_size  out  32  BPB 0x24..0x27
sectors_per_cluster  out  8  BPB 0x0D
root_cluster  out  32  BPB 0x2C..0x2F
fat_start_lba  out  32  partition_lba + reserved_sectors
data_start_lba  out  32  fat_start_lba + num_fats*fat_size
root_dir_lba  out  32  data_start_lba + (root_cluster-2)*sectors_per_cluster

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0.
- Reset mid-operation aborts immediately: rd_req drops on the same edge and subsequent bytes are ignored.
- States: IDLE, REQ, STREAM, CHECK, CALC0, CALC1, CALC2, DONE, ERR.
- IDLE/DONE/ERR + start:
  - clear done, error and error_code; set busy; go to REQ.
  - rd_lba = 0 on the first pass, partition_lba on the second pass.
  - start while busy is ignored.
- REQ: rd_req=1 until the edge sampling rd_ack=1, then rd_req=0 and go to STREAM with the 10-bit byte counter at 0.
- STREAM:
  - Each byte_valid cycle captures fields by counter index (little-endian), then increments the counter.
  - Also captured: 0x00 (jump opcode), 0x0B..0x0C (bytes/sector), 0x1C6..0x1C9 (partition entry 0 LBA), 0x1FE..0x1FF (signature).
  - The byte at index SECTOR_BYTES-1 moves the state to CHECK.
  - byte_valid outside STREAM is ignored.
- CHECK, evaluated in this order:
  - signature != 55 AA -> ERR, code 1.
  - VBR means byte0 in {EB, E9} and bytes/sector == SECTOR_BYTES.
  - Non-VBR on the first pass with USE_MBR=1:
    - partition LBA == 0 -> ERR, code 3.
    - otherwise latch partition_lba and go to REQ (second pass).
  - Non-VBR otherwise -> ERR, code 2.
  - VBR with num_fats not 1/2, spc zero or not a power of two, or root_cluster < 2 -> ERR, code 3.
  - Otherwise -> CALC0.
- CALC0 computes fat_start_lba; CALC1 data_start_lba; CALC2 root_dir_lba, with the spc multiply done as a shift.
- All arithmetic is 32-bit modulo 2^32.
- done and busy change on the edge leaving CALC2; done rises on the 5th edge after the edge accepting the last byte.
- ERR: error=1, busy=0.
- Result outputs hold until the next start or reset.

Test Plan:
1. VBR at LBA 0 (EB, bps 512, rsvd 32, fats 2, fat_size 961, spc 8, root_cluster 2) -> one read of LBA 0; fat_start 32; data_start 1954; root_dir 1954; done 5 cycles after byte 511.
2. MBR in sector 0 (byte0 0xFA, entry LBA 8192), VBR at 8192 with the same BPB but root_cluster 5 -> second rd_lba 8192; fat_start 8224; data_start 10146; root_dir 10170.
3. Sector 0 ending 55 AB -> error=1, code 1, busy=0, one read only.
4. VBR with spc 6, then a separate run with num_fats 3 -> code 3 for each run.
5. rd_ack delayed 7 cycles with byte_valid gaps -> rd_req held with LBA stable; same results as test 1.
6. sys_rst asserted at byte 200, then start with test-1 data -> all outputs 0 after reset; second run matches test 1.
